// File: rtl/data_ram.sv
// ============================================================================
//  Module      : data_ram
//  Description : Flop-array RAM with a fixed-latency, single-outstanding read
//                and a sticky error flag for requests made while busy.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int BUS_WIDTH  = 8,
    parameter int RD_LATENCY = 2    // legal range 1..4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  ram_rd_en,
    input  logic                  ram_wr_en,
    input  logic [BUS_WIDTH-1:0]  addr_rd,
    input  logic [BUS_WIDTH-1:0]  addr_wr,
    input  logic [DATA_WIDTH-1:0] data_wr,
    output logic [DATA_WIDTH-1:0] data_rd,
    output logic                  ram_busy,
    output logic                  rd_valid,
    output logic                  drop_err
);

    localparam int DEPTH = 2 ** BUS_WIDTH;
    localparam int CNT_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic [BUS_WIDTH-1:0]    addr_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]   data_rd_q;
    logic                    busy_q;
    logic                    valid_q;
    logic                    drop_q;

    assign cnt_d    = cnt_q - 3'd1;
    assign data_rd  = data_rd_q;
    assign ram_busy = busy_q;
    assign rd_valid = valid_q;
    assign drop_err = drop_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_rd_q <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            drop_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // The write lands at this edge, so a same-address read
                    // completing later naturally sees the new word.
                    if (ram_wr_en) begin
                        mem_q[addr_wr] <= data_wr;
                    end
                    if (ram_rd_en) begin
                        addr_q  <= addr_rd;
                        cnt_q   <= CNT_W'(RD_LATENCY);
                        busy_q  <= 1'b1;
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (ram_rd_en || ram_wr_en) begin
                        drop_q <= 1'b1;
                    end
                    cnt_q <= cnt_d;
                    if (cnt_q == 3'd1) begin
                        data_rd_q <= mem_q[addr_q];
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of one data word.
REQ-002 Parameter BUS_WIDTH, default 8, address width; depth is 2**BUS_WIDTH words.
REQ-003 Parameter RD_LATENCY, default 2, legal range 1..4, cycles from read acceptance to data.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 ram_rd_en  input  1  read request, level-sampled each rising edge.
REQ-007 ram_wr_en  input  1  write request, level-sampled each rising edge.
REQ-008 addr_rd  input  BUS_WIDTH  read address.
REQ-009 addr_wr  input  BUS_WIDTH  write address.
REQ-010 data_wr  input  DATA_WIDTH  write data.
REQ-011 data_rd  output  DATA_WIDTH  read data, registered, holds last completed read.
REQ-012 ram_busy  output  1  high while a read is in flight.
REQ-013 rd_valid  output  1  one-cycle pulse, coincident with new data_rd.
REQ-014 drop_err  output  1  sticky flag, request arrived while ram_busy was high.

Function
REQ-015 Storage SHALL be a 2**BUS_WIDTH x DATA_WIDTH flop array with no address wrap logic; addresses are used as-is.
REQ-016 FSM SHALL have states IDLE and READ.
REQ-017 In IDLE with ram_wr_en=1 at an edge, mem[addr_wr] SHALL take data_wr at that same edge, and the state SHALL remain IDLE.
REQ-018 In IDLE with ram_rd_en=1 at an edge, addr_rd SHALL be latched, a down-counter SHALL be loaded with RD_LATENCY, and the state SHALL go to READ.
REQ-019 ram_busy SHALL be a registered output, equal to 1 exactly while the state is READ.
REQ-020 In READ, the counter SHALL decrement each edge.
  - At the edge where the counter equals 1: data_rd <= mem[latched addr], rd_valid <= 1 for the following cycle, state -> IDLE.
REQ-021 Read latency SHALL be fixed: the request accepted at edge N yields rd_valid=1 and valid data_rd in the cycle after edge N+RD_LATENCY.
REQ-022 Simultaneous ram_rd_en and ram_wr_en in IDLE:
  - Both SHALL be accepted.
  - The write commits first; if addr_rd==addr_wr, the read returns the new data_wr.
REQ-023 Any ram_rd_en or ram_wr_en sampled while in READ SHALL be ignored, with no memory change, and SHALL set drop_err=1.
REQ-024 drop_err SHALL clear only on reset.
REQ-025 A new read SHALL NOT be accepted on the edge that completes a read, because the state is still READ at that edge.
  - The earliest back-to-back accept is the next edge.
  - A request present on the completing edge counts as dropped.
REQ-026 data_rd SHALL change only on read completion or reset.
REQ-027 rd_valid SHALL be low in every cycle other than REQ-020 completion cycles.

Reset
REQ-028 On rstn=0, asynchronously:
  - state = IDLE, counter = 0.
  - ram_busy = 0, rd_valid = 0, drop_err = 0, data_rd = 0.
  - All memory words = 0.
REQ-029 Reset asserted mid-read SHALL abort the read with no rd_valid pulse, and SHALL leave no pending state after rstn returns high.
REQ-030 The first request SHALL be accepted at the first rising edge with rstn=1.

Verification
REQ-031 RD_LATENCY=2: write 0x1234 @0x10, then read @0x10 -> ram_busy high 2 cycles, rd_valid pulse 2 edges after accept, data_rd=0x1234.
REQ-032 Same-edge write 0xBEEF @0x20 and read @0x20 from IDLE -> data_rd=0xBEEF, rd_valid pulses once.
REQ-033 Read @0x05 accepted, write 0x5555 @0x05 issued while busy -> mem[0x05] unchanged (read returns 0), drop_err=1 and stays 1.
REQ-034 Back-to-back reads @0x01 then @0x02, second request raised on the edge after completion -> two rd_valid pulses, correct data each, drop_err=0.
REQ-035 rstn pulsed low during READ -> ram_busy=0 and no rd_valid immediately, data_rd=0, all words read back as 0.
REQ-036 RD_LATENCY=1 and RD_LATENCY=4 builds: read @0xFF (top address) -> latency exactly 1 and 4 cycles respectively.
